// File: rtl/cdr_loop_filter.sv
// Second-order CDR loop filter: majority-decimated bang-bang votes drive a saturating
// frequency integrator and a wrapping phase accumulator. Optional lock detector: CDR_LOCK_DET_EN.
module cdr_loop_filter #(
   parameter int PI_WIDTH   = 10,
   parameter int FRAC_WIDTH = 5,
   parameter int FI_WIDTH   = 16,
   parameter int KP_SHIFT   = 3,
   parameter int DECIM      = 4,
   parameter int RUN_MAX    = 4,
   parameter int LOCK_CNT   = 64
) (
   input  logic                CLK,
   input  logic                RST_n,
   input  logic                phe_valid,
   input  logic [1:0]          phe,
   input  logic [1:0]          ki_sel,
   input  logic                freeze,
   output logic [PI_WIDTH-1:0] control2PMIX,
   output logic                ctrl_valid,
   output logic [FI_WIDTH-1:0] freq_word,
   output logic                locked
);

   localparam int PW = PI_WIDTH + FRAC_WIDTH;
   localparam int CW = $clog2(DECIM + 1);
   localparam int SW = CW + 1;
   localparam int FW = FI_WIDTH + 2;
   localparam logic [FW-1:0] FI_MAX = {3'b000, {(FI_WIDTH-1){1'b1}}};
   localparam logic [FW-1:0] FI_MIN = {3'b111, {(FI_WIDTH-1){1'b0}}};

   // Sign-extend or truncate the integrator to the accumulator width (PA arithmetic is modulo).
   function automatic logic [PW-1:0] fi_to_pa(input logic [FI_WIDTH-1:0] v);
      logic [PW-1:0] r;
      int            j;
      r = {PW{1'b0}};
      for (int i = 0; i < PW; i++) begin
         j    = (i < FI_WIDTH) ? i : FI_WIDTH - 1;
         r[i] = v[j];
      end
      return r;
   endfunction

   logic [SW-1:0]       sum_q, sum_d, pv_s, sum_new_s;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                upd_q, upd_d;
   logic [1:0]          vote_q, vote_d;
   logic [FI_WIDTH-1:0] fi_q, fi_d;
   logic [PW-1:0]       pa_q, pa_d, kp_s;
   logic                pend_q, pend_d;
   logic [PI_WIDTH-1:0] ctrl_q, ctrl_d;
   logic                ctrl_valid_q, ctrl_valid_d;
   logic signed [FW-1:0] fi_sum_s, inc_s;

`ifdef CDR_LOCK_DET_EN
   localparam int RW = $clog2(RUN_MAX + 1);
   localparam int LW = $clog2(LOCK_CNT + 1);
   logic [RW-1:0] run_q, run_d;
   logic [1:0]    last_q, last_d;
   logic [LW-1:0] lock_q, lock_d;
   logic          locked_q, locked_d;
`endif

   // Next-state logic for decimator, integrators, output stage and lock detector.
   always_comb begin
      sum_d        = sum_q;
      cnt_d        = cnt_q;
      upd_d        = 1'b0;
      vote_d       = vote_q;
      fi_d         = fi_q;
      pa_d         = pa_q;
      pend_d       = pend_q;
      ctrl_d       = ctrl_q;
      ctrl_valid_d = 1'b0;
      inc_s        = {{FI_WIDTH{vote_q[1]}}, vote_q} << ki_sel;
      fi_sum_s     = {{2{fi_q[FI_WIDTH-1]}}, fi_q} + inc_s;
      kp_s         = {{(PW-2){vote_q[1]}}, vote_q} << KP_SHIFT;
`ifdef CDR_LOCK_DET_EN
      run_d    = run_q;
      last_d   = last_q;
      lock_d   = lock_q;
      locked_d = locked_q;
`endif
      case (phe)
         2'b01:   pv_s = {{(SW-1){1'b0}}, 1'b1};
         2'b10:   pv_s = {SW{1'b1}};
         default: pv_s = {SW{1'b0}};
      endcase
      sum_new_s = sum_q + pv_s;

      if (freeze) begin
         sum_d = {SW{1'b0}};
         cnt_d = {CW{1'b0}};
      end else begin
         if (phe_valid) begin
            if (cnt_q == CW'(DECIM - 1)) begin
               if (sum_new_s == {SW{1'b0}}) begin
                  vote_d = 2'b00;
               end else if (sum_new_s[SW-1]) begin
                  vote_d = 2'b11;
               end else begin
                  vote_d = 2'b01;
               end
               upd_d = 1'b1;
               sum_d = {SW{1'b0}};
               cnt_d = {CW{1'b0}};
            end else begin
               sum_d = sum_new_s;
               cnt_d = cnt_q + CW'(1);
            end
         end else begin
            sum_d = sum_q;
         end

         if (pend_q) begin
            ctrl_d       = pa_q[PW-1:FRAC_WIDTH];
            ctrl_valid_d = 1'b1;
            pend_d       = 1'b0;
         end else begin
            pend_d = 1'b0;
         end

         // PA uses the pre-update FI; FI saturates, PA wraps.
         if (upd_q) begin
            if (fi_sum_s > $signed(FI_MAX)) begin
               fi_d = FI_MAX[FI_WIDTH-1:0];
            end else if (fi_sum_s < $signed(FI_MIN)) begin
               fi_d = FI_MIN[FI_WIDTH-1:0];
            end else begin
               fi_d = fi_sum_s[FI_WIDTH-1:0];
            end
            pa_d   = pa_q + fi_to_pa(fi_q) + kp_s;
            pend_d = 1'b1;
`ifdef CDR_LOCK_DET_EN
            if (vote_q == 2'b00) begin
               run_d = {RW{1'b0}};
            end else if (vote_q == last_q) begin
               run_d = (run_q == RW'(RUN_MAX)) ? run_q : run_q + RW'(1);
            end else begin
               run_d = RW'(1);
            end
            last_d = vote_q;
            if (run_d == RW'(RUN_MAX)) begin
               lock_d = {LW{1'b0}};
            end else if (lock_q != LW'(LOCK_CNT)) begin
               lock_d = lock_q + LW'(1);
            end else begin
               lock_d = lock_q;
            end
            locked_d = (lock_d == LW'(LOCK_CNT));
`endif
         end else begin
            fi_d = fi_q;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         sum_q        <= {SW{1'b0}};
         cnt_q        <= {CW{1'b0}};
         upd_q        <= 1'b0;
         vote_q       <= 2'b00;
         fi_q         <= {FI_WIDTH{1'b0}};
         pa_q         <= {PW{1'b0}};
         pend_q       <= 1'b0;
         ctrl_q       <= {PI_WIDTH{1'b0}};
         ctrl_valid_q <= 1'b0;
`ifdef CDR_LOCK_DET_EN
         run_q        <= {RW{1'b0}};
         last_q       <= 2'b00;
         lock_q       <= {LW{1'b0}};
         locked_q     <= 1'b0;
`endif
      end else begin
         sum_q        <= sum_d;
         cnt_q        <= cnt_d;
         upd_q        <= upd_d;
         vote_q       <= vote_d;
         fi_q         <= fi_d;
         pa_q         <= pa_d;
         pend_q       <= pend_d;
         ctrl_q       <= ctrl_d;
         ctrl_valid_q <= ctrl_valid_d;
`ifdef CDR_LOCK_DET_EN
         run_q        <= run_d;
         last_q       <= last_d;
         lock_q       <= lock_d;
         locked_q     <= locked_d;
`endif
      end
   end

   assign control2PMIX = ctrl_q;
   assign ctrl_valid   = ctrl_valid_q;
   assign freq_word    = fi_q;
`ifdef CDR_LOCK_DET_EN
   assign locked = locked_q;
`else
   assign locked = 1'b0;
`endif

endmodule
